// File: rtl/delta_reader.sv
// Consumer side of a delta-register bank: round-robin picks one pending change flag,
// pulses its read/clear line, captures the value and offers {channel, data} downstream.
module delta_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16,
    localparam int IDX_WIDTH   = $clog2(NUM_CHANNELS)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               EN,
    input  logic [NUM_CHANNELS-1:0]            VALUE_CHANGE,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] VALUE_IN,
    output logic [NUM_CHANNELS-1:0]            READ_EVENT,
    output logic                               EVT_VALID,
    input  logic                               EVT_READY,
    output logic [IDX_WIDTH-1:0]               EVT_CHANNEL,
    output logic [DATA_WIDTH-1:0]              EVT_DATA,
    output logic [CNT_WIDTH-1:0]               EVT_COUNT,
    output logic                               BUSY
);

    typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

    state_t                  state, state_nxt;
    logic [IDX_WIDTH-1:0]    rr_ptr, rr_ptr_nxt;
    logic [IDX_WIDTH-1:0]    sel, sel_nxt;
    logic [IDX_WIDTH-1:0]    grant, scan_idx;
    logic                    grant_found;
    logic [NUM_CHANNELS-1:0] read_event_nxt;
    logic                    evt_valid_nxt;
    logic [IDX_WIDTH-1:0]    evt_channel_nxt;
    logic [DATA_WIDTH-1:0]   evt_data_nxt;
    logic [CNT_WIDTH-1:0]    evt_count_nxt;
    logic                    busy_nxt;
    logic [DATA_WIDTH-1:0]   chan_val [NUM_CHANNELS];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
        assign chan_val[i] = VALUE_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Cyclic scan starting at rr_ptr; the first set flag found wins.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            scan_idx = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_CHANNELS);
            if (!grant_found && VALUE_CHANGE[scan_idx]) begin
                grant       = scan_idx;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        sel_nxt         = sel;
        read_event_nxt  = '0;
        evt_valid_nxt   = EVT_VALID;
        evt_channel_nxt = EVT_CHANNEL;
        evt_data_nxt    = EVT_DATA;
        evt_count_nxt   = EVT_COUNT;
        case (state)
            IDLE: begin
                if (EN && grant_found) begin
                    sel_nxt        = grant;
                    rr_ptr_nxt     = (grant == IDX_WIDTH'(NUM_CHANNELS - 1)) ? '0 : grant + IDX_WIDTH'(1);
                    read_event_nxt = NUM_CHANNELS'(1) << grant;
                    state_nxt      = READ;
                end
            end
            READ: begin
                evt_data_nxt    = chan_val[sel];
                evt_channel_nxt = sel;
                evt_valid_nxt   = 1'b1;
                state_nxt       = OUT;
            end
            OUT: begin
                if (EVT_READY) begin
                    evt_valid_nxt = 1'b0;
                    evt_count_nxt = (EVT_COUNT == '1) ? EVT_COUNT : EVT_COUNT + CNT_WIDTH'(1);
                    state_nxt     = IDLE;
                end
            end
            default: begin
                evt_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Reset aborts any transaction in flight; the source keeps unread flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sel         <= '0;
            READ_EVENT  <= '0;
            EVT_VALID   <= 1'b0;
            EVT_CHANNEL <= '0;
            EVT_DATA    <= '0;
            EVT_COUNT   <= '0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            sel         <= sel_nxt;
            READ_EVENT  <= read_event_nxt;
            EVT_VALID   <= evt_valid_nxt;
            EVT_CHANNEL <= evt_channel_nxt;
            EVT_DATA    <= evt_data_nxt;
            EVT_COUNT   <= evt_count_nxt;
            BUSY        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_delta_reader.sv
// Bench for delta_reader: a delta-register source model, a transaction-level reference
// model checked every cycle, directed literal checks and a randomized phase.
module tb_delta_reader;

    localparam int NCH     = 4;
    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int IW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic            EN;
    logic            EVT_READY;
    logic            EVT_VALID;
    logic            BUSY;
    logic [NCH-1:0]  VALUE_CHANGE;
    logic [NCH-1:0]  READ_EVENT;
    logic [NCH*DW-1:0] VALUE_IN;
    logic [IW-1:0]   EVT_CHANNEL;
    logic [DW-1:0]   EVT_DATA;
    logic [CW-1:0]   EVT_COUNT;

    logic [NCH-1:0]  flags     = '0;
    logic [NCH-1:0]  raise_req = '0;
    logic [DW-1:0]   vals [NCH];

    int tests_run    = 0;
    int tests_failed = 0;

    delta_reader #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NCH),
        .CNT_WIDTH    (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .EN           (EN),
        .VALUE_CHANGE (VALUE_CHANGE),
        .VALUE_IN     (VALUE_IN),
        .READ_EVENT   (READ_EVENT),
        .EVT_VALID    (EVT_VALID),
        .EVT_READY    (EVT_READY),
        .EVT_CHANNEL  (EVT_CHANNEL),
        .EVT_DATA     (EVT_DATA),
        .EVT_COUNT    (EVT_COUNT),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    // Delta-register source: a read pulse clears a flag, a new change (re)raises it.
    always @(posedge CLK) flags <= (flags & ~READ_EVENT) | raise_req;
    assign VALUE_CHANGE = flags;

    always_comb begin
        VALUE_IN = '0;
        for (int i = 0; i < NCH; i++) VALUE_IN[i*DW +: DW] = vals[i];
    end

    // Reference model: one outstanding transaction, aged in cycles since its grant.
    bit             m_known  = 1'b0;
    bit             m_active = 1'b0;
    int             m_age, m_chan, m_rec_chan, m_rr, m_count;
    logic [DW-1:0]  m_data;
    logic [NCH-1:0] prev_re = '0;

    function automatic int pickChannel(input logic [NCH-1:0] f, input int start);
        logic [NCH-1:0] sh;
        for (int k = 0; k < NCH; k++) begin
            sh = f >> ((start + k) % NCH);
            if (sh[0]) return (start + k) % NCH;
        end
        return -1;
    endfunction

    task automatic modelStep();
        int g;
        if (RST) begin
            m_known = 1'b1; m_active = 1'b0; m_age = 0; m_chan = 0;
            m_rec_chan = 0; m_rr = 0; m_count = 0; m_data = '0;
        end else if (m_known) begin
            if (!m_active) begin
                g = pickChannel(VALUE_CHANGE, m_rr);
                if (EN && g >= 0) begin
                    m_active = 1'b1; m_age = 1; m_chan = g; m_rr = (g + 1) % NCH;
                end
            end else if (m_age == 1) begin
                m_data = vals[m_chan]; m_rec_chan = m_chan; m_age = 2;
            end else if (EVT_READY) begin
                m_active = 1'b0; m_age = 0;
                if (m_count < CNT_MAX) m_count++;
            end
        end
    endtask

    task automatic compareOutputs();
        logic [NCH-1:0] exp_re;
        logic           exp_valid;
        if (!m_known) return;
        exp_re    = (m_active && m_age == 1) ? (NCH'(1) << m_chan) : '0;
        exp_valid = m_active && m_age == 2;
        tests_run++;
        if (READ_EVENT !== exp_re || EVT_VALID !== exp_valid || EVT_CHANNEL !== IW'(m_rec_chan) ||
            EVT_DATA !== m_data || EVT_COUNT !== CW'(m_count) || BUSY !== m_active) begin
            tests_failed++;
            $display("[TB] FAIL model t=%0t: got re=%b v=%b ch=%0d d=%h cnt=%0d busy=%b, expected re=%b v=%b ch=%0d d=%h cnt=%0d busy=%b",
                     $time, READ_EVENT, EVT_VALID, EVT_CHANNEL, EVT_DATA, EVT_COUNT, BUSY,
                     exp_re, exp_valid, m_rec_chan, m_data, m_count, m_active);
        end
        tests_run++;
        assert ($onehot0(READ_EVENT) && !(READ_EVENT != 0 && prev_re != 0) && !(READ_EVENT != 0 && EVT_VALID))
        else begin
            tests_failed++;
            $display("[TB] FAIL invariant t=%0t: got re=%b prev_re=%b v=%b, expected zero/one-hot, no back-to-back, not with valid",
                     $time, READ_EVENT, prev_re, EVT_VALID);
        end
        prev_re = READ_EVENT;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            modelStep();
            @(negedge CLK);
            compareOutputs();
        end
    end

    // Drives one cycle of inputs from a falling edge and returns at the next falling edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic rdy, input logic [NCH-1:0] raise);
        RST = rst; EN = en; EVT_READY = rdy; raise_req = raise;
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [NCH-1:0] e_re, input logic e_v,
                               input logic [IW-1:0] e_ch, input logic [DW-1:0] e_d,
                               input logic [CW-1:0] e_cnt, input logic e_busy);
        tests_run++;
        if (READ_EVENT !== e_re || EVT_VALID !== e_v || EVT_CHANNEL !== e_ch ||
            EVT_DATA !== e_d || EVT_COUNT !== e_cnt || BUSY !== e_busy) begin
            tests_failed++;
            $display("[TB] FAIL %s: got re=%b v=%b ch=%0d d=%h cnt=%0d busy=%b, expected re=%b v=%b ch=%0d d=%h cnt=%0d busy=%b",
                     name, READ_EVENT, EVT_VALID, EVT_CHANNEL, EVT_DATA, EVT_COUNT, BUSY,
                     e_re, e_v, e_ch, e_d, e_cnt, e_busy);
        end
    endtask

    task automatic drainFlags();
        int n = 0;
        while ((flags != 0 || BUSY) && n < 60) begin
            applyStimulus(1'b0, 1'b1, 1'b1, '0);
            n++;
        end
        tests_run++;
        if (flags != 0 || BUSY) begin
            tests_failed++;
            $display("[TB] FAIL drain: got flags=%b busy=%b, expected flags=0000 busy=0", flags, BUSY);
        end
    endtask

    task automatic finishRun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    endtask

    initial begin
        #1000000;
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL watchdog: got no end of stimulus, expected completion before 1ms");
        finishRun();
    end

    initial begin
        int grants, last, cyc, evts;
        logic [NCH-1:0] rnd;
        RST = 1'b1; EN = 1'b0; EVT_READY = 1'b0;
        for (int i = 0; i < NCH; i++) vals[i] = '0;
        @(negedge CLK);

        $display("[TB] reset then idle");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("reset", '0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, '0);
            checkOutput("idle", '0, 1'b0, '0, '0, '0, 1'b0);
        end

        $display("[TB] single event");
        vals[2] = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b0100);
        checkOutput("single_flag", '0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("single_read", 4'b0100, 1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("single_valid", '0, 1'b1, 2'd2, 32'hDEADBEEF, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("single_accept", '0, 1'b0, 2'd2, 32'hDEADBEEF, 4'd1, 1'b0);

        $display("[TB] round robin");
        applyStimulus(1'b1, 1'b1, 1'b1, '0);
        for (int i = 0; i < NCH; i++) vals[i] = 32'h1000_0000 + i;
        grants = 0; last = 0; cyc = 0;
        while (grants < 6 && cyc < 60) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
            cyc++;
            if (READ_EVENT != 0) begin
                tests_run++;
                if (READ_EVENT !== (NCH'(1) << (grants % NCH)) || (grants > 0 && cyc - last != 3)) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_grant%0d: got re=%b gap=%0d, expected re=%b gap=3",
                             grants, READ_EVENT, cyc - last, NCH'(1) << (grants % NCH));
                end
                last = cyc;
                grants++;
            end
        end
        if (grants < 6) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL rr_timeout: got %0d grants, expected 6", grants);
        end
        drainFlags();

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        vals[1] = 32'h11111111;
        vals[3] = 32'h33333333;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1010);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("bp_grant", 4'b0010, 1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("bp_valid", '0, 1'b1, 2'd1, 32'h11111111, '0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            checkOutput("bp_hold", '0, 1'b1, 2'd1, 32'h11111111, '0, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("bp_accept", '0, 1'b0, 2'd1, 32'h11111111, 4'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("bp_next_grant", 4'b1000, 1'b0, 2'd1, 32'h11111111, 4'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("bp_next_valid", '0, 1'b1, 2'd3, 32'h33333333, 4'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("bp_next_accept", '0, 1'b0, 2'd3, 32'h33333333, 4'd2, 1'b0);

        $display("[TB] enable drop and reset mid-transaction");
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        vals[0] = 32'hA5A5A5A5;
        vals[2] = 32'hC3C3C3C3;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b0101);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("en_grant0", 4'b0001, 1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("en_drop_valid", '0, 1'b1, 2'd0, 32'hA5A5A5A5, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("en_drop_accept", '0, 1'b0, 2'd0, 32'hA5A5A5A5, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, '0);
            checkOutput("en_low_no_grant", '0, 1'b0, 2'd0, 32'hA5A5A5A5, 4'd1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("en_regrant", 4'b0100, 1'b0, 2'd0, 32'hA5A5A5A5, 4'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("rst_pre_out", '0, 1'b1, 2'd2, 32'hC3C3C3C3, 4'd1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("rst_during_out", '0, 1'b0, '0, '0, '0, 1'b0);
        vals[2] = 32'h5A5A5A5A;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b0100);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("rst_reread_grant", 4'b0100, 1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("rst_reread_valid", '0, 1'b1, 2'd2, 32'h5A5A5A5A, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        checkOutput("rst_reread_accept", '0, 1'b0, 2'd2, 32'h5A5A5A5A, 4'd1, 1'b0);

        $display("[TB] counter saturation");
        applyStimulus(1'b1, 1'b1, 1'b1, '0);
        evts = 0; cyc = 0;
        while (evts < 20 && cyc < 200) begin
            for (int i = 0; i < NCH; i++) vals[i] = $urandom;
            applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
            cyc++;
            if (EVT_VALID) evts++;
        end
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        tests_run++;
        if (evts < 20 || EVT_COUNT !== 4'd15) begin
            tests_failed++;
            $display("[TB] FAIL saturation: got %0d events cnt=%0d, expected 20 events cnt=15", evts, EVT_COUNT);
        end
        drainFlags();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                rnd[i] = ($urandom_range(0, 5) == 0);
                if (rnd[i]) vals[i] = $urandom;
            end
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 1)), rnd);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        finishRun();
    end

endmodule
